// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Holds opcode constants, ALU/PC-source/ALU-B select codes, the controller
// state enum and the packed bundle of Moore control outputs.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12
    } ctrl_state_t;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       IorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic       instr_retire;
    } ctrl_out_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master : controller side (drives control strobes, receives opcode/mem_ready)
//   slave  : datapath/memory side
interface mips_multicycle_ctrl_if #(parameter int STATE_W = 4);
    logic [5:0]         opcode;
    logic               mem_ready;
    logic               pcWrite;
    logic               pcWriteCond;
    logic               IorD;
    logic               memRead;
    logic               memWrite;
    logic               memToReg;
    logic               irWrite;
    logic [1:0]         pcSource;
    logic [1:0]         aluOp;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic               regWrite;
    logic               regDst;
    logic               illegal_op;
    logic               instr_retire;
    logic [STATE_W-1:0] dbg_state;

    modport master (
        input  opcode, mem_ready,
        output pcWrite, pcWriteCond, IorD, memRead, memWrite, memToReg, irWrite,
               pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst,
               illegal_op, instr_retire, dbg_state
    );

    modport slave (
        output opcode, mem_ready,
        input  pcWrite, pcWriteCond, IorD, memRead, memWrite, memToReg, irWrite,
               pcSource, aluOp, aluSrcA, aluSrcB, regWrite, regDst,
               illegal_op, instr_retire, dbg_state
    );
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder for the multicycle controller.
//   state_i     : current controller state
//   mem_ready_i : effective memory-ready (already forced to 1 when handshake is off)
//   ctrl_o      : datapath control bundle
// Optional feature macro: MIPS_CTRL_ADDI_EN (adds ADDIEX/ADDIWB decode).
module mips_ctrl_outdec
    import mips_pkg::*;
(
    input  ctrl_state_t state_i,
    input  logic        mem_ready_i,
    output ctrl_out_t   ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.memRead = 1'b1;
                ctrl_o.aluSrcB = SRCB_FOUR;
                ctrl_o.aluOp   = ALUOP_ADD;
                ctrl_o.pcSource = PCSRC_ALU;
                // IR/PC only advance on the cycle the fetch actually completes
                ctrl_o.irWrite = mem_ready_i;
                ctrl_o.pcWrite = mem_ready_i;
            end
            ST_DECODE: begin
                ctrl_o.aluSrcB = SRCB_IMMSH;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_IMM;
            end
            ST_MEMRD: begin
                ctrl_o.IorD    = 1'b1;
                ctrl_o.memRead = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.regWrite     = 1'b1;
                ctrl_o.memToReg     = 1'b1;
                ctrl_o.instr_retire = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_o.IorD         = 1'b1;
                ctrl_o.memWrite     = 1'b1;
                ctrl_o.instr_retire = mem_ready_i;
            end
            ST_EXEC: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_REGB;
                ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl_o.regWrite     = 1'b1;
                ctrl_o.regDst       = 1'b1;
                ctrl_o.instr_retire = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.aluSrcA      = 1'b1;
                ctrl_o.aluOp        = ALUOP_SUB;
                ctrl_o.pcWriteCond  = 1'b1;
                ctrl_o.pcSource     = PCSRC_ALUOUT;
                ctrl_o.instr_retire = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pcWrite      = 1'b1;
                ctrl_o.pcSource     = PCSRC_JUMP;
                ctrl_o.instr_retire = 1'b1;
            end
`ifdef MIPS_CTRL_ADDI_EN
            ST_ADDIEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_IMM;
            end
            ST_ADDIWB: begin
                ctrl_o.regWrite     = 1'b1;
                ctrl_o.instr_retire = 1'b1;
            end
`endif
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core (state register + next state).
//   clk, rst : system clock, async active-high reset
//   bus      : master modport of mips_multicycle_ctrl_if (opcode/mem_ready in,
//              all datapath controls, illegal_op, instr_retire, dbg_state out)
// Parameters: MEM_HANDSHAKE (0 = mem_ready treated as 1), STATE_W (dbg_state width).
// Optional feature macro: MIPS_CTRL_ADDI_EN (decodes opcode 0x08 as addi).
//
// state  | meaning
// RESET  | held in / just out of reset, all outputs 0
// FETCH  | read instruction at PC, PC+4 (waits for mem_ready)
// DECODE | branch target into aluOut, dispatch on opcode
// MEMADR | effective address for lw/sw
// MEMRD  | data read (waits for mem_ready)
// MEMWB  | MDR -> rt
// MEMWR  | data write (waits for mem_ready)
// EXEC   | R-type ALU operation
// ALUWB  | aluOut -> rd
// BRANCH | beq compare and conditional PC write
// JUMP   | PC <- jump target
// ADDIEX | addi ALU operation (macro only)
// ADDIWB | aluOut -> rt (macro only)
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int STATE_W       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_multicycle_ctrl_if.master  bus
);

    ctrl_state_t state_q, state_d;
    ctrl_out_t   ctrl;
    logic        mem_rdy;
    logic        illegal;

    assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  if (mem_rdy) state_d = ST_DECODE;
            ST_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
`ifdef MIPS_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_ADDIEX;
`endif
                    default: begin
                        state_d = ST_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR: state_d = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem_rdy) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (mem_rdy) state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
`ifdef MIPS_CTRL_ADDI_EN
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
`endif
            default:   state_d = ST_RESET;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_rdy),
        .ctrl_o      (ctrl)
    );

    assign bus.pcWrite      = ctrl.pcWrite;
    assign bus.pcWriteCond  = ctrl.pcWriteCond;
    assign bus.IorD         = ctrl.IorD;
    assign bus.memRead      = ctrl.memRead;
    assign bus.memWrite     = ctrl.memWrite;
    assign bus.memToReg     = ctrl.memToReg;
    assign bus.irWrite      = ctrl.irWrite;
    assign bus.pcSource     = ctrl.pcSource;
    assign bus.aluOp        = ctrl.aluOp;
    assign bus.aluSrcA      = ctrl.aluSrcA;
    assign bus.aluSrcB      = ctrl.aluSrcB;
    assign bus.regWrite     = ctrl.regWrite;
    assign bus.regDst       = ctrl.regDst;
    // An unknown opcode retires straight out of DECODE
    assign bus.illegal_op   = illegal;
    assign bus.instr_retire = ctrl.instr_retire | illegal;
    assign bus.dbg_state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       IorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       regWrite;
        logic       regDst;
        logic       illegal_op;
        logic       instr_retire;
    } cv_t;

    typedef struct {
        logic [5:0] op;
        int         stalls;
        int         lat;
        int         rw;
        int         mw;
        int         il;
    } vec_t;

    // Instruction steps as named in the behavioural description
    localparam int K_RESET = 0, K_FETCH = 1, K_DECODE = 2, K_MEMADR = 3, K_MEMRD = 4,
                   K_MEMWB = 5, K_MEMWR = 6, K_EXEC = 7, K_ALUWB = 8, K_BRANCH = 9,
                   K_JUMP = 10, K_ADDIEX = 11, K_ADDIWB = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.STATE_W(4)) bus ();
    mips_multicycle_ctrl_if #(.STATE_W(4)) bus0 ();

    mips_multicycle_ctrl #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    mips_multicycle_ctrl #(.MEM_HANDSHAKE(0), .STATE_W(4)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int total  = 0;
    int passed = 0;
    int path[$];
    bit path_ill;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h at t=%0t", name, act, exp, $time);
    endtask

    function automatic cv_t samp();
        return '{bus.pcWrite, bus.pcWriteCond, bus.IorD, bus.memRead, bus.memWrite,
                 bus.memToReg, bus.irWrite, bus.pcSource, bus.aluOp, bus.aluSrcA,
                 bus.aluSrcB, bus.regWrite, bus.regDst, bus.illegal_op, bus.instr_retire};
    endfunction

    function automatic cv_t samp0();
        return '{bus0.pcWrite, bus0.pcWriteCond, bus0.IorD, bus0.memRead, bus0.memWrite,
                 bus0.memToReg, bus0.irWrite, bus0.pcSource, bus0.aluOp, bus0.aluSrcA,
                 bus0.aluSrcB, bus0.regWrite, bus0.regDst, bus0.illegal_op, bus0.instr_retire};
    endfunction

    // Expected outputs for one step, straight from the per-step output lists
    function automatic cv_t exp_vec(input int step, input bit rdy, input bit ill);
        cv_t v = '0;
        case (step)
            K_FETCH:  begin v.memRead = 1; v.aluSrcB = 2'b01; v.irWrite = rdy; v.pcWrite = rdy; end
            K_DECODE: begin v.aluSrcB = 2'b11; v.illegal_op = ill; v.instr_retire = ill; end
            K_MEMADR: begin v.aluSrcA = 1; v.aluSrcB = 2'b10; end
            K_MEMRD:  begin v.IorD = 1; v.memRead = 1; end
            K_MEMWB:  begin v.regWrite = 1; v.memToReg = 1; v.instr_retire = 1; end
            K_MEMWR:  begin v.IorD = 1; v.memWrite = 1; v.instr_retire = rdy; end
            K_EXEC:   begin v.aluSrcA = 1; v.aluOp = 2'b10; end
            K_ALUWB:  begin v.regWrite = 1; v.regDst = 1; v.instr_retire = 1; end
            K_BRANCH: begin v.aluSrcA = 1; v.aluOp = 2'b01; v.pcWriteCond = 1;
                            v.pcSource = 2'b01; v.instr_retire = 1; end
            K_JUMP:   begin v.pcWrite = 1; v.pcSource = 2'b11; v.instr_retire = 1; end
            K_ADDIEX: begin v.aluSrcA = 1; v.aluSrcB = 2'b10; end
            K_ADDIWB: begin v.regWrite = 1; v.instr_retire = 1; end
            default:  v = '0;
        endcase
        return v;
    endfunction

    function automatic bit is_wait(input int step);
        return (step == K_FETCH) || (step == K_MEMRD) || (step == K_MEMWR);
    endfunction

    // Instruction -> ordered list of steps
    function automatic void build_path(input logic [5:0] op);
        path = '{K_FETCH, K_DECODE};
        path_ill = 0;
        case (op)
            6'h23: begin path.push_back(K_MEMADR); path.push_back(K_MEMRD); path.push_back(K_MEMWB); end
            6'h2B: begin path.push_back(K_MEMADR); path.push_back(K_MEMWR); end
            6'h00: begin path.push_back(K_EXEC); path.push_back(K_ALUWB); end
            6'h04: path.push_back(K_BRANCH);
            6'h02: path.push_back(K_JUMP);
`ifdef MIPS_CTRL_ADDI_EN
            6'h08: begin path.push_back(K_ADDIEX); path.push_back(K_ADDIWB); end
`endif
            default: path_ill = 1;
        endcase
    endfunction

    // Random mem_ready each cycle; opcode only meaningful in DECODE/MEMADR, garbage elsewhere
    task automatic run_model(input logic [5:0] op);
        int idx = 0;
        int guard = 0;
        int step;
        build_path(op);
        while (idx < path.size() && guard < 200) begin
            @(negedge clk);
            step = path[idx];
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            bus.opcode = (step == K_DECODE || step == K_MEMADR) ? op : 6'($urandom);
            #1;
            chk($sformatf("model op=%h step=%0d", op, step), 32'(samp()),
                32'(exp_vec(step, bus.mem_ready, path_ill && step == K_DECODE)));
            if (!(is_wait(step) && !bus.mem_ready)) idx++;
            guard++;
        end
        if (guard >= 200) chk("model timeout", 32'(guard), 32'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int cyc = 0, rw = 0, mw = 0, il = 0, sl = v.stalls;
        bit done = 0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            bus.opcode = v.op;
            bus.mem_ready = 1;
            #1;
            if (bus.IorD && (bus.memRead || bus.memWrite) && sl > 0) begin
                bus.mem_ready = 0;
                sl--;
            end
            #1;
            cyc++;
            rw += int'(bus.regWrite);
            mw += int'(bus.memWrite);
            il += int'(bus.illegal_op);
            if (bus.instr_retire) done = 1;
        end
        chk($sformatf("latency op=%h", v.op), 32'(cyc), 32'(v.lat));
        chk($sformatf("regWrite cycles op=%h", v.op), 32'(rw), 32'(v.rw));
        chk($sformatf("memWrite cycles op=%h", v.op), 32'(mw), 32'(v.mw));
        chk($sformatf("illegal pulses op=%h", v.op), 32'(il), 32'(v.il));
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h3F};

        vecs[0] = '{6'h00, 0, 4, 1, 0, 0};
        vecs[1] = '{6'h23, 2, 7, 1, 0, 0};
        vecs[2] = '{6'h23, 0, 5, 1, 0, 0};
        vecs[3] = '{6'h2B, 0, 4, 0, 1, 0};
        vecs[4] = '{6'h2B, 1, 5, 0, 2, 0};
        vecs[5] = '{6'h04, 0, 3, 0, 0, 0};
        vecs[6] = '{6'h02, 0, 3, 0, 0, 0};
        vecs[7] = '{6'h3F, 0, 2, 0, 0, 1};
`ifdef MIPS_CTRL_ADDI_EN
        vecs[8] = '{6'h08, 0, 4, 1, 0, 0};
`else
        vecs[8] = '{6'h08, 0, 2, 0, 0, 1};
`endif

        // Reset, then R-type up to EXEC, async reset mid-EXEC
        rst = 1;
        bus.opcode = 6'h00; bus.mem_ready = 1;
        bus0.opcode = 6'h02; bus0.mem_ready = 0;
        #12;
        chk("reset outputs", 32'(samp()), 32'(0));
        chk("reset outputs hs0", 32'(samp0()), 32'(0));
        @(negedge clk); rst = 0; #1;
        chk("post-release RESET", 32'(samp()), 32'(0));
        @(negedge clk); #1;
        chk("first FETCH", 32'(samp()), 32'(exp_vec(K_FETCH, 1, 0)));
        chk("hs0 FETCH ignores mem_ready", 32'(samp0()), 32'(exp_vec(K_FETCH, 1, 0)));
        @(negedge clk); #1;
        chk("R DECODE", 32'(samp()), 32'(exp_vec(K_DECODE, 1, 0)));
        chk("hs0 DECODE", 32'(samp0()), 32'(exp_vec(K_DECODE, 1, 0)));
        @(negedge clk); #1;
        chk("R EXEC", 32'(samp()), 32'(exp_vec(K_EXEC, 1, 0)));
        chk("hs0 JUMP", 32'(samp0()), 32'(exp_vec(K_JUMP, 1, 0)));
        rst = 1; #1;
        chk("async reset mid-EXEC", 32'(samp()), 32'(0));
        @(negedge clk); rst = 0; #1;
        chk("RESET after mid-EXEC reset", 32'(samp()), 32'(0));

        // Fetch stall: 3 cycles not ready, then ready
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.mem_ready = 0; bus.opcode = 6'($urandom); #1;
            chk($sformatf("fetch stall %0d", i), 32'(samp()), 32'(exp_vec(K_FETCH, 0, 0)));
        end
        @(negedge clk); bus.mem_ready = 1; #1;
        chk("fetch ready irWrite", 32'(bus.irWrite), 32'(1));
        chk("fetch ready pcWrite", 32'(bus.pcWrite), 32'(1));
        @(negedge clk); bus.opcode = 6'h02; #1;
        chk("j DECODE", 32'(samp()), 32'(exp_vec(K_DECODE, 1, 0)));
        @(negedge clk); bus.opcode = 6'h23; #1;
        chk("j JUMP ignores opcode", 32'(samp()), 32'(exp_vec(K_JUMP, 1, 0)));

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            run_model(op);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
